// File: rtl/monitor_contador_modulo15.sv
// rtl/monitor_contador_modulo15.sv - sequence monitor for 4-bit up/down bounce counters
//
// Locks onto a bounce counter's output sequence (0..MAX..0), predicts the next
// value and flags direction, endpoint events, round trips and sequence errors.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   en           sample strobe; cont_in is evaluated only when en=1
//   cont_in      observed counter value (WIDTH bits)
//   modo         0 = immediate reversal, 1 = dwell one sample at 0 and MAX
//   sincronizado high while locked onto the sequence
//   decresce     high while the tracked counter counts down
//   pico         one-cycle pulse: MAX seen on an up-run
//   vale         one-cycle pulse: 0 seen on a down-run
//   erro         one-cycle pulse: sample differs from the prediction
//   ciclos       completed round trips, wraps (CW bits)
//   erros        error count, saturates (CW bits)

module monitor_contador_modulo15 #(
    parameter int WIDTH = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cont_in,
    input  logic             modo,
    output logic             sincronizado,
    output logic             decresce,
    output logic             pico,
    output logic             vale,
    output logic             erro,
    output logic [CW-1:0]    ciclos,
    output logic [CW-1:0]    erros
);

    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic [2:0] {
        SYNC,
        UP,
        HOLD_TOP,
        DOWN,
        HOLD_BOT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] exp_val;
    logic             modo_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SYNC;
            exp_val      <= ZERO;
            modo_l       <= 1'b0;
            sincronizado <= 1'b0;
            decresce     <= 1'b0;
            pico         <= 1'b0;
            vale         <= 1'b0;
            erro         <= 1'b0;
            ciclos       <= '0;
            erros        <= '0;
        end else begin
            // Pulses default low; they only rise for an accepted sample.
            pico <= 1'b0;
            vale <= 1'b0;
            erro <= 1'b0;
            if (en) begin
                if (state == SYNC) begin
                    // Only a 0 sample gives a known phase to lock onto.
                    if (cont_in == ZERO) begin
                        modo_l       <= modo;
                        exp_val      <= ONE;
                        state        <= UP;
                        sincronizado <= 1'b1;
                        decresce     <= 1'b0;
                    end
                end else if (cont_in != exp_val) begin
                    // Mismatch wins over endpoint events; the bad sample is
                    // discarded rather than used to relock.
                    erro         <= 1'b1;
                    if (erros != '1)
                        erros <= erros + 1'b1;
                    state        <= SYNC;
                    sincronizado <= 1'b0;
                    decresce     <= 1'b0;
                end else begin
                    case (state)
                        UP: begin
                            if (cont_in == MAX) begin
                                pico     <= 1'b1;
                                decresce <= 1'b1;
                                if (modo_l) begin
                                    state   <= HOLD_TOP;
                                    exp_val <= MAX;
                                end else begin
                                    state   <= DOWN;
                                    exp_val <= MAX - 1'b1;
                                end
                            end else begin
                                exp_val <= cont_in + 1'b1;
                            end
                        end
                        HOLD_TOP: begin
                            state   <= DOWN;
                            exp_val <= MAX - 1'b1;
                        end
                        DOWN: begin
                            if (cont_in == ZERO) begin
                                vale     <= 1'b1;
                                ciclos   <= ciclos + 1'b1;
                                decresce <= 1'b0;
                                if (modo_l) begin
                                    state   <= HOLD_BOT;
                                    exp_val <= ZERO;
                                end else begin
                                    state   <= UP;
                                    exp_val <= ONE;
                                end
                            end else begin
                                exp_val <= cont_in - 1'b1;
                            end
                        end
                        HOLD_BOT: begin
                            state   <= UP;
                            exp_val <= ONE;
                        end
                        default: begin
                            state        <= SYNC;
                            sincronizado <= 1'b0;
                            decresce     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_monitor_contador_modulo15.sv
// tb/tb_monitor_contador_modulo15.sv - self-checking bench for monitor_contador_modulo15

module tb_monitor_contador_modulo15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] cont_in = 4'd0;
    logic       modo = 1'b0;
    logic       sincronizado, decresce, pico, vale, erro;
    logic [7:0] ciclos, erros;

    monitor_contador_modulo15 #(.WIDTH(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .cont_in(cont_in), .modo(modo),
        .sincronizado(sincronizado), .decresce(decresce), .pico(pico),
        .vale(vale), .erro(erro), .ciclos(ciclos), .erros(erros)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    string cur_tag = "reset";

    // Reference model: tracks last value, direction and a pending dwell.
    bit m_locked, m_down, m_dwell, m_ml;
    bit m_pico, m_vale, m_erro;
    int m_last, m_ciclos, m_erros;

    logic [20:0] sb[$];

    task automatic model_step(input logic r, input logic e, input int s, input logic m);
        int expv;
        m_pico = 0; m_vale = 0; m_erro = 0;
        if (r) begin
            m_locked = 0; m_down = 0; m_dwell = 0; m_ml = 0;
            m_last = 0; m_ciclos = 0; m_erros = 0;
            return;
        end
        if (!e) return;
        if (!m_locked) begin
            if (s == 0) begin
                m_locked = 1; m_ml = m; m_down = 0; m_dwell = 0; m_last = 0;
            end
            return;
        end
        expv = m_dwell ? m_last : (m_down ? m_last - 1 : m_last + 1);
        if (s != expv) begin
            m_erro = 1;
            if (m_erros < 255) m_erros++;
            m_locked = 0; m_down = 0; m_dwell = 0;
            return;
        end
        if (m_dwell) m_dwell = 0;
        else if (!m_down && s == 15) begin
            m_pico = 1; m_down = 1; m_dwell = m_ml;
        end else if (m_down && s == 0) begin
            m_vale = 1; m_ciclos = (m_ciclos + 1) % 256; m_down = 0; m_dwell = m_ml;
        end
        m_last = s;
    endtask

    task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] req);
        assert (obs === req) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] v, input logic m);
        logic [20:0] req;
        @(negedge clk);
        rst = r; en = e; cont_in = v; modo = m;
        model_step(r, e, int'(v), m);
        sb.push_back({m_locked, m_locked & m_down, m_pico, m_vale, m_erro,
                      8'(m_ciclos), 8'(m_erros)});
        @(posedge clk);
        #1;
        req = sb.pop_front();
        check(cur_tag, {sincronizado, decresce, pico, vale, erro, ciclos, erros}, req);
    endtask

    task automatic samp(input int v, input logic m);
        step(1'b0, 1'b1, 4'(v), m);
    endtask

    task automatic trip_body(input logic m);
        for (int i = 1; i <= 15; i++) samp(i, m);
        if (m) samp(15, m);
        for (int i = 14; i >= 0; i--) samp(i, m);
        if (m) samp(0, m);
    endtask

    initial begin
        cur_tag = "reset";
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 4'd7, 1'b1);

        cur_tag = "mode0_trip";
        samp(0, 0);
        trip_body(0);
        samp(1, 0);
        check("mode0_ciclos", {13'd0, ciclos}, 21'd1);

        cur_tag = "mode1_trip";
        step(1'b1, 1'b0, 4'd0, 1'b0);
        samp(0, 1);
        trip_body(1);
        samp(1, 1);
        check("mode1_ciclos", {13'd0, ciclos}, 21'd1);

        cur_tag = "mode1_missing_dwell";
        step(1'b1, 1'b0, 4'd0, 1'b0);
        samp(0, 1);
        for (int i = 1; i <= 15; i++) samp(i, 1);
        samp(14, 1);
        check("mode1_err", {19'd0, erro, sincronizado}, 21'b10);

        cur_tag = "error_relock";
        step(1'b1, 1'b0, 4'd0, 1'b0);
        samp(0, 0); samp(1, 0); samp(2, 0); samp(4, 0);
        check("relock_erros", {13'd0, erros}, 21'd1);
        samp(5, 0); samp(0, 0); samp(1, 0);

        cur_tag = "strobe_gap";
        step(1'b1, 1'b0, 4'd0, 1'b0);
        samp(0, 0);
        for (int i = 1; i <= 7; i++) samp(i, 0);
        for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 4'($urandom_range(15)), 1'b1);
        for (int i = 8; i <= 15; i++) samp(i, 0);
        for (int i = 14; i >= 0; i--) samp(i, 0);

        cur_tag = "erros_saturation";
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 300; k++) begin
            samp(0, 0);
            samp(5, 0);
        end
        check("erros_255", {13'd0, erros}, 21'd255);

        cur_tag = "ciclos_wrap";
        step(1'b1, 1'b0, 4'd0, 1'b0);
        samp(0, 0);
        for (int k = 0; k < 257; k++) trip_body(0);
        check("ciclos_wrap_1", {13'd0, ciclos}, 21'd1);

        cur_tag = "reset_midrun";
        step(1'b1, 1'b0, 4'd0, 1'b0);
        samp(0, 0);
        for (int i = 1; i <= 15; i++) samp(i, 0);
        for (int i = 14; i >= 9; i--) samp(i, 0);
        step(1'b1, 1'b1, 4'd8, 1'b0);
        check("reset_all_zero", {sincronizado, decresce, pico, vale, erro, ciclos, erros}, 21'd0);
        samp(8, 0); samp(7, 0); samp(0, 0);
        check("reset_relock", {20'd0, sincronizado}, 21'd1);

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end

endmodule

// File: doc/monitor_contador_modulo15.md
# monitor_contador_modulo15

Sequence monitor for the 4-bit up/down bounce counters. It samples a counter's output bus, locks onto the bounce sequence and predicts every next value. It reports direction, endpoint events, completed round trips and sequence errors. It sits on the receiving side of any bounce-counter output in the design and is also used as a self-checking probe in benches. Both counter flavours are supported:
- **Immediate reversal:** …14,15,14…1,0,1…
- **Dwell:** …14,15,15,14…1,0,0,1…

## Interface
- `WIDTH`, default 4: counter bus width. `MAX` = 2^WIDTH−1.
- `CW`, default 8: width of the `ciclos` and `erros` counters.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  sample strobe. `cont_in` is evaluated only in cycles where `en`=1.
- `cont_in`  in  WIDTH  observed counter value.
- `modo`  in  1  0 = immediate reversal, 1 = dwell one sample at 0 and MAX.
- `sincronizado`  out  1  high while locked onto the sequence.
- `decresce`  out  1  high while the tracked counter is counting down.
- `pico`  out  1  one-cycle pulse: MAX observed on an up-run.
- `vale`  out  1  one-cycle pulse: 0 observed on a down-run.
- `erro`  out  1  one-cycle pulse: observed sample differs from the expected value.
- `ciclos`  out  CW  completed round trips (0→MAX→0), wraps modulo 2^CW.
- `erros`  out  CW  error count, saturates at 2^CW−1.

## Operation
- **Registers:** state, `exp` (WIDTH bits), `modo_l`, and all outputs. Every output is a register.
- **States:** SYNC, UP, HOLD_TOP, DOWN, HOLD_BOT. "Match" means the sample equals `exp`.
- **SYNC:**
  - Sample 0: latch `modo_l`←`modo`, set `exp`=1, go to UP.
  - Any other sample: stay in SYNC, no error.
- **UP, on match:**
  - Sample < MAX: `exp`←sample+1.
  - Sample = MAX: `pico` pulses. With `modo_l`=0, go to DOWN with `exp`=MAX−1. With `modo_l`=1, go to HOLD_TOP with `exp`=MAX.
- **HOLD_TOP, on match:** go to DOWN with `exp`=MAX−1.
- **DOWN, on match:**
  - Sample > 0: `exp`←sample−1.
  - Sample = 0: `vale` pulses and `ciclos` increments. With `modo_l`=0, go to UP with `exp`=1. With `modo_l`=1, go to HOLD_BOT with `exp`=0.
- **HOLD_BOT, on match:** go to UP with `exp`=1.
- **Mismatch in any tracking state:**
  - `erro` pulses and `erros` increments (saturating).
  - Next state is SYNC. The mismatched sample itself is not used to relock.
- **Outputs by state:**
  - `sincronizado`=1 in every state except SYNC.
  - `decresce`=1 in DOWN and HOLD_TOP, 0 otherwise.
- **`modo` handling:** `modo` is read only when locking in SYNC. Changes while tracking are ignored until the next SYNC.
- **`en`=0:** state, `exp` and counters hold. All pulse outputs are 0 in that cycle.
- **Arithmetic:**
  - `exp` never wraps: ±1 is applied only away from 0 and MAX.
  - `ciclos` wraps from 2^CW−1 to 0.
  - `erros` sticks at 2^CW−1.

## Timing
- **Latency:** 1 cycle. A sample accepted at edge N updates state and outputs visible after edge N, i.e. during cycle N+1.
- **Pulses:** `pico`, `vale` and `erro` are high for exactly one cycle per triggering sample. They are never asserted in the same cycle as each other.
- **Simultaneous event:** a mismatch on a sample of value 0 or MAX gives `erro` only. No `pico`/`vale`, no `ciclos` increment.
- **Reset:**
  - `rst`=1 at an edge forces state to SYNC; `exp`, `modo_l`, `ciclos` and `erros` to 0; every output to 0. This happens regardless of `en`.
  - Reset mid-run discards the lock. The first post-reset 0 sample relocks.
- **No back-pressure:** every `en` cycle is consumed.

## Test plan
- **Mode 0 full trip:** `modo`=0, `en`=1, drive 0,1…15,14…0,1.
  - `sincronizado` rises after the first 0.
  - `pico` pulses once, after 15.
  - `decresce` is 1 from after 15 until after the return to 0.
  - `vale` pulses once and `ciclos`=1.
  - `erro` never asserts.
- **Mode 1 dwell:** `modo`=1, drive 0,1…15,15,14…0,0,1.
  - Same `pico`/`vale`/`ciclos`=1 result as mode 0.
  - Driving 0,1…15,14 instead gives `erro` after the 14, `erros`=1, `sincronizado`=0.
- **Error and relock:** `modo`=0, drive 0,1,2,4.
  - `erro` pulses after the 4, `erros`=1, state SYNC.
  - Then drive 5,0,1: no further error, relocked after the 0.
- **Strobe gaps:** `modo`=0, mode 0 sequence with `en` dropped for 3 cycles between 7 and 8, with `cont_in` held at garbage values during the gap. No error; outputs hold during the gap.
- **Saturation and wrap:**
  - 300 forced mismatches (alternate 0, 5): `erros`=255.
  - 257 clean round trips: `ciclos`=1.
- **Reset mid-run:** assert `rst` while tracking down at value 9.
  - Next cycle all outputs are 0.
  - The following 8,7 samples cause no error (unlocked); lock occurs on the next 0.
